// File: rtl/seven_segment_reader_pkg.sv
// Shared seven-segment definitions: active-low segment patterns (bit0=a .. bit6=g),
// the dark pattern, default reader parameters and the dwell FSM state type.
package seven_segment_reader_pkg;

   localparam int DEFAULT_SETTLE        = 4;
   localparam int DEFAULT_STABLE_FRAMES = 2;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic {
      DWELL_WAIT    = 1'b0,
      DWELL_SAMPLED = 1'b1
   } dwell_state_e;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] pattern;
      case (nibble)
         4'h0:    pattern = SEG_0;
         4'h1:    pattern = SEG_1;
         4'h2:    pattern = SEG_2;
         4'h3:    pattern = SEG_3;
         4'h4:    pattern = SEG_4;
         4'h5:    pattern = SEG_5;
         4'h6:    pattern = SEG_6;
         4'h7:    pattern = SEG_7;
         4'h8:    pattern = SEG_8;
         4'h9:    pattern = SEG_9;
         4'hA:    pattern = SEG_A;
         4'hB:    pattern = SEG_B;
         4'hC:    pattern = SEG_C;
         4'hD:    pattern = SEG_D;
         4'hE:    pattern = SEG_E;
         default: pattern = SEG_F;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/seven_segment_encoder.sv
// Combinational pattern classifier: maps an active-low segment pattern back to
// its hex nibble, flagging the dark pattern and anything outside the table.
module seven_segment_encoder
   import seven_segment_reader_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       is_blank,
   output logic       is_invalid
);

   always_comb begin
      nibble     = 4'h0;
      is_blank   = (seg == SEG_BLANK);
      is_invalid = (seg != SEG_BLANK);
      for (int i = 0; i < 16; i++) begin
         if (seg == hex_to_seg(4'(i))) begin
            nibble     = 4'(i);
            is_invalid = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seven_segment_reader.sv
// Recovers the hex value shown on a multiplexed 4-digit seven-segment display by
// sampling each digit after a settle dwell and publishing once frames agree.
module seven_segment_reader
   import seven_segment_reader_pkg::*;
#(
   parameter int SETTLE        = DEFAULT_SETTLE,
   parameter int STABLE_FRAMES = DEFAULT_STABLE_FRAMES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [6:0]   seg,
   input  logic [3:0]   an,
   output logic [15:0]  value,
   output logic [3:0]   blank,
   output logic         valid,
   output logic         err,
   output dwell_state_e dwell_state
);

   localparam logic [7:0] SETTLE_LAST   = 8'(SETTLE - 1);
   localparam logic [3:0] STABLE_TARGET = 4'(STABLE_FRAMES);

   logic [3:0]   an_q, an_d;
   logic [7:0]   cnt_q, cnt_d;
   dwell_state_e state_q, state_d;
   logic [15:0]  digits_q, digits_d;
   logic [3:0]   blanks_q, blanks_d;
   logic [3:0]   mask_q, mask_d;
   logic         bad_q, bad_d;
   logic [15:0]  prev_digits_q, prev_digits_d;
   logic [3:0]   prev_blanks_q, prev_blanks_d;
   logic         prev_ok_q, prev_ok_d;
   logic [3:0]   stable_q, stable_d;
   logic         first_q, first_d;
   logic [15:0]  value_q, value_d;
   logic [3:0]   blank_q, blank_d;
   logic         valid_q, valid_d;
   logic         err_q, err_d;

   logic [3:0]   dec_nibble;
   logic         dec_blank;
   logic         dec_invalid;
   logic         sample;
   logic [1:0]   slot;

   seven_segment_encoder u_encoder (
      .seg        (seg),
      .nibble     (dec_nibble),
      .is_blank   (dec_blank),
      .is_invalid (dec_invalid)
   );

   // an_q lags an by one edge, so at the sample edge the live seg belongs to an_q.
   always_comb begin
      slot = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!an_q[i]) slot = 2'(i);
      end
   end

   always_comb begin
      an_d          = an;
      cnt_d         = cnt_q;
      state_d       = state_q;
      digits_d      = digits_q;
      blanks_d      = blanks_q;
      mask_d        = mask_q;
      bad_d         = bad_q;
      prev_digits_d = prev_digits_q;
      prev_blanks_d = prev_blanks_q;
      prev_ok_d     = prev_ok_q;
      stable_d      = stable_q;
      first_d       = first_q;
      value_d       = value_q;
      blank_d       = blank_q;
      valid_d       = 1'b0;
      err_d         = 1'b0;
      sample        = 1'b0;

      if ((an != an_q) || !$onehot(~an_q)) begin
         state_d = DWELL_WAIT;
         cnt_d   = 8'd0;
      end else if (state_q == DWELL_WAIT) begin
         if (cnt_q == SETTLE_LAST) begin
            state_d = DWELL_SAMPLED;
            sample  = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end

      // A completed frame is judged from the registered buffer; a capture on the
      // same edge lands in the freshly cleared mask and belongs to the next frame.
      if (mask_q == 4'hF) begin
         mask_d = 4'h0;
         bad_d  = 1'b0;
         if (bad_q) begin
            stable_d  = 4'd0;
            prev_ok_d = 1'b0;
         end else begin
            if (prev_ok_q && (digits_q == prev_digits_q) && (blanks_q == prev_blanks_q))
               stable_d = (stable_q >= STABLE_TARGET) ? STABLE_TARGET : stable_q + 4'd1;
            else
               stable_d = 4'd1;
            prev_digits_d = digits_q;
            prev_blanks_d = blanks_q;
            prev_ok_d     = 1'b1;
            if ((stable_d == STABLE_TARGET) &&
                (first_q || (digits_q != value_q) || (blanks_q != blank_q))) begin
               value_d = digits_q;
               blank_d = blanks_q;
               valid_d = 1'b1;
               first_d = 1'b0;
            end
         end
      end

      if (sample) begin
         digits_d[{slot, 2'b00} +: 4] = dec_nibble;
         blanks_d[slot]               = dec_blank;
         mask_d[slot]                 = 1'b1;
         if (dec_invalid) begin
            bad_d = 1'b1;
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q          <= 4'hF;
         cnt_q         <= 8'd0;
         state_q       <= DWELL_WAIT;
         digits_q      <= 16'h0000;
         blanks_q      <= 4'h0;
         mask_q        <= 4'h0;
         bad_q         <= 1'b0;
         prev_digits_q <= 16'h0000;
         prev_blanks_q <= 4'h0;
         prev_ok_q     <= 1'b0;
         stable_q      <= 4'd0;
         first_q       <= 1'b1;
         value_q       <= 16'h0000;
         blank_q       <= 4'h0;
         valid_q       <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         an_q          <= an_d;
         cnt_q         <= cnt_d;
         state_q       <= state_d;
         digits_q      <= digits_d;
         blanks_q      <= blanks_d;
         mask_q        <= mask_d;
         bad_q         <= bad_d;
         prev_digits_q <= prev_digits_d;
         prev_blanks_q <= prev_blanks_d;
         prev_ok_q     <= prev_ok_d;
         stable_q      <= stable_d;
         first_q       <= first_d;
         value_q       <= value_d;
         blank_q       <= blank_d;
         valid_q       <= valid_d;
         err_q         <= err_d;
      end
   end

   assign value       = value_q;
   assign blank       = blank_q;
   assign valid       = valid_q;
   assign err         = err_q;
   assign dwell_state = state_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: drives multiplexed digit scans and compares the
// published values and error pulses with a frame-level reference model.
module tb_seven_segment_reader;
   import seven_segment_reader_pkg::*;

   localparam int SETTLE        = 4;
   localparam int STABLE_FRAMES = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [6:0]   seg;
   logic [3:0]   an;
   logic [15:0]  value;
   logic [3:0]   blank;
   logic         valid;
   logic         err;
   dwell_state_e dwell_state;

   int n_vec = 0;
   int n_err = 0;

   logic [6:0] ref_pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Reference model state: a frame is four captured digits; publishes queue up here.
   logic [15:0] m_frame, m_prev, m_pub;
   logic [3:0]  m_fblank, m_prevb, m_pubb, m_mask;
   bit          m_bad, m_prev_ok, m_first;
   int          m_stable;
   int          exp_err, obs_err;
   logic [19:0] exp_q[$];
   logic [19:0] obs_q[$];

   always #5 clk = ~clk;

   seven_segment_reader #(.SETTLE(SETTLE), .STABLE_FRAMES(STABLE_FRAMES)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg         (seg),
      .an          (an),
      .value       (value),
      .blank       (blank),
      .valid       (valid),
      .err         (err),
      .dwell_state (dwell_state)
   );

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (valid === 1'b1) obs_q.push_back({blank, value});
         if (err === 1'b1) obs_err++;
      end
   end

   function automatic bit pattern_invalid(input logic [6:0] s);
      bit bad = (s != 7'h7F);
      for (int i = 0; i < 16; i++) if (s == ref_pat[i]) bad = 0;
      return bad;
   endfunction

   task automatic model_reset;
      m_frame = '0; m_fblank = '0; m_mask = '0; m_bad = 0;
      m_prev = '0; m_prevb = '0; m_prev_ok = 0; m_stable = 0;
      m_pub = '0; m_pubb = '0; m_first = 1;
   endtask

   task automatic model_capture(input int d, input logic [6:0] s);
      int nib = 0;
      for (int i = 0; i < 16; i++) if (s == ref_pat[i]) nib = i;
      m_frame[4*d +: 4] = 4'(nib);
      m_fblank[d]       = (s == 7'h7F);
      m_mask[d]         = 1'b1;
      if (pattern_invalid(s)) begin
         m_bad = 1;
         exp_err++;
      end
      if (m_mask == 4'hF) begin
         if (m_bad) begin
            m_stable  = 0;
            m_prev_ok = 0;
         end else begin
            if (m_prev_ok && m_frame == m_prev && m_fblank == m_prevb)
               m_stable = (m_stable + 1 > STABLE_FRAMES) ? STABLE_FRAMES : m_stable + 1;
            else
               m_stable = 1;
            m_prev = m_frame; m_prevb = m_fblank; m_prev_ok = 1;
            if (m_stable == STABLE_FRAMES && (m_first || m_frame != m_pub || m_fblank != m_pubb)) begin
               exp_q.push_back({m_fblank, m_frame});
               m_pub = m_frame; m_pubb = m_fblank; m_first = 0;
            end
         end
         m_mask = 4'h0;
         m_bad  = 0;
      end
   endtask

   // Holds one select/pattern for len edges; long dwells capture, short ones never do.
   task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
      int d = 0;
      an  = a;
      seg = s;
      repeat (len) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (!a[i]) d = i;
      if ($countones(~a) == 1 && len >= 2 * SETTLE) model_capture(d, s);
   endtask

   task automatic idle(input int len);
      dwell(4'hF, 7'h7F, len);
   endtask

   task automatic scan_word(input logic [15:0] w, input logic [3:0] bl, input int len);
      logic [3:0] nib;
      for (int d = 3; d >= 0; d--) begin
         nib = w[4*d +: 4];
         dwell(4'(~(4'b0001 << d)), bl[d] ? 7'h7F : ref_pat[nib], len);
      end
   endtask

   task automatic clear_board;
      obs_q.delete(); exp_q.delete();
      obs_err = 0; exp_err = 0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; an = 4'hF; seg = 7'h7F;
      model_reset();
      clear_board();
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({value, blank, valid, err} !== 22'h0) begin
         n_err++;
         $display("FAIL reset_outputs actual value=%h blank=%b valid=%b err=%b required 0", value, blank, valid, err);
      end
      n_vec++;
      if (dwell_state !== DWELL_WAIT) begin
         n_err++;
         $display("FAIL reset_state actual=%0d required=%0d", dwell_state, DWELL_WAIT);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_scan_1234;
      clear_board();
      repeat (2) scan_word(16'h1234, 4'h0, 8);
      idle(4);
      n_vec++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
         n_err++;
         $display("FAIL scan_1234_count actual=%0d required=1 (model %0d)", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL scan_1234_pub[%0d] actual=%h required=%h", i, obs_q[i], exp_q[i]);
         end
      end
      n_vec++;
      if (value !== 16'h1234 || blank !== 4'h0 || obs_err != 0) begin
         n_err++;
         $display("FAIL scan_1234_final actual value=%h blank=%b errs=%0d required 1234/0000/0", value, blank, obs_err);
      end
   endtask

   task automatic test_short_dwell;
      clear_board();
      repeat (3) scan_word(16'h5678, 4'h0, 3);
      idle(4);
      n_vec++;
      if (obs_q.size() != exp_q.size() || obs_q.size() != 0 || obs_err != exp_err) begin
         n_err++;
         $display("FAIL short_dwell actual valids=%0d errs=%0d required 0/0", obs_q.size(), obs_err);
      end
      n_vec++;
      if (value !== 16'h1234) begin
         n_err++;
         $display("FAIL short_dwell_value actual=%h required=1234", value);
      end
   endtask

   task automatic test_bad_frame;
      clear_board();
      dwell(4'b0111, ref_pat[0], 8);
      dwell(4'b1011, 7'b1010101, 8);
      dwell(4'b1101, ref_pat[10], 8);
      dwell(4'b1110, ref_pat[0], 8);
      scan_word(16'h00A0, 4'h0, 8);
      idle(4);
      n_vec++;
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL bad_frame_early_valid actual=%0d required=0 (model %0d)", obs_q.size(), exp_q.size());
      end
      scan_word(16'h00A0, 4'h0, 8);
      idle(4);
      n_vec++;
      if (obs_q.size() != exp_q.size() || obs_q.size() != 1) begin
         n_err++;
         $display("FAIL bad_frame_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL bad_frame_pub[%0d] actual=%h required=%h", i, obs_q[i], exp_q[i]);
         end
      end
      n_vec++;
      if (obs_err != exp_err || obs_err != 1 || value !== 16'h00A0) begin
         n_err++;
         $display("FAIL bad_frame_err actual errs=%0d value=%h required errs=%0d value=00a0", obs_err, value, exp_err);
      end
   endtask

   task automatic test_blank_digit;
      clear_board();
      repeat (2) scan_word(16'h0F0E, 4'b1000, 8);
      idle(4);
      n_vec++;
      if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
         n_err++;
         $display("FAIL blank_digit_pub actual count=%0d required 1 entry %h", obs_q.size(), {4'b1000, 16'h0F0E});
      end
      n_vec++;
      if (value !== 16'h0F0E || blank !== 4'b1000 || obs_err != 0) begin
         n_err++;
         $display("FAIL blank_digit_final actual value=%h blank=%b errs=%0d required 0f0e/1000/0", value, blank, obs_err);
      end
   endtask

   task automatic test_beef_cafe;
      clear_board();
      repeat (3) scan_word(16'hBEEF, 4'h0, 8);
      repeat (3) scan_word(16'hCAFE, 4'h0, 8);
      idle(4);
      n_vec++;
      if (obs_q.size() != 2 || exp_q.size() != 2) begin
         n_err++;
         $display("FAIL beef_cafe_count actual=%0d required=2 (model %0d)", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL beef_cafe_pub[%0d] actual=%h required=%h", i, obs_q[i], exp_q[i]);
         end
      end
      n_vec++;
      if (value !== 16'hCAFE || obs_err != 0) begin
         n_err++;
         $display("FAIL beef_cafe_final actual value=%h errs=%0d required cafe/0", value, obs_err);
      end
   endtask

   task automatic test_reset_mid_frame;
      clear_board();
      dwell(4'b0111, ref_pat[1], 8);
      dwell(4'b1011, ref_pat[3], 8);
      #2;
      rst_n = 1'b0; an = 4'hF; seg = 7'h7F;
      #1;
      n_vec++;
      if ({value, blank, valid, err} !== 22'h0) begin
         n_err++;
         $display("FAIL mid_reset_outputs actual value=%h blank=%b valid=%b err=%b required 0", value, blank, valid, err);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      repeat (2) begin
         @(negedge clk);
         n_vec++;
         if (valid !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_release actual valid=%b err=%b required 0/0", valid, err);
         end
      end
      @(posedge clk);
      #1;
      scan_word(16'hCAFE, 4'h0, 8);
      idle(4);
      n_vec++;
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL mid_reset_one_frame actual=%0d required=0", obs_q.size());
      end
      scan_word(16'hCAFE, 4'h0, 8);
      idle(4);
      n_vec++;
      if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0] || value !== 16'hCAFE) begin
         n_err++;
         $display("FAIL mid_reset_republish actual count=%0d value=%h required 1/cafe", obs_q.size(), value);
      end
   endtask

   task automatic test_random;
      logic [15:0] w;
      logic [3:0]  bl, nib;
      logic [6:0]  s;
      int          reps, len;
      clear_board();
      for (int n = 0; n < 20; n++) begin
         w    = 16'($urandom);
         bl   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         reps = $urandom_range(1, 3);
         for (int r = 0; r < reps; r++) begin
            if ($urandom_range(0, 4) == 0)
               dwell(($urandom_range(0, 1) == 0) ? 4'hF : 4'b0011, 7'h7F, $urandom_range(1, 10));
            for (int d = 3; d >= 0; d--) begin
               nib = w[4*d +: 4];
               s   = bl[d] ? 7'h7F : ref_pat[nib];
               if ($urandom_range(0, 15) == 0) begin
                  do s = 7'($urandom_range(0, 127)); while (!pattern_invalid(s));
               end
               len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : $urandom_range(8, 10);
               dwell(4'(~(4'b0001 << d)), s, len);
            end
         end
      end
      idle(6);
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL random_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL random_pub[%0d] actual=%h required=%h", i, obs_q[i], exp_q[i]);
         end
      end
      n_vec++;
      if (obs_err != exp_err) begin
         n_err++;
         $display("FAIL random_errs actual=%0d required=%0d", obs_err, exp_err);
      end
      n_vec++;
      if (value !== m_pub || blank !== m_pubb) begin
         n_err++;
         $display("FAIL random_final actual=%h/%b required=%h/%b", value, blank, m_pub, m_pubb);
      end
   endtask

   initial begin
      test_reset();
      test_scan_1234();
      test_short_dwell();
      test_bad_frame();
      test_blank_digit();
      test_beef_cafe();
      test_reset_mid_frame();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      n_err++;
      $display("FAIL watchdog actual=timeout required=completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
